axi_dma_mm2s_lite_ctrl: RTL and testbench



---
 rtl/axi_dma_mm2s_lite_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_axi_dma_mm2s_lite_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_mm2s_lite_ctrl.sv
// AXI4-Lite master that programs an AXI DMA MM2S channel (CR, SA, LENGTH),
// then polls DMASR until idle/IOC, reporting completion and errors.
// Ports: M_AXI_ACLK/M_AXI_ARESETN clock and async low reset; INIT_AXI_TXN
// start request (rising edge); M_AXI_* AXI4-Lite master channels
// AW/W/B/AR/R; TXN_DONE completion level; ERROR sticky error flag.
module axi_dma_mm2s_lite_ctrl #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter logic [31:0] C_SRC_ADDR                 = 32'h1000_0000,
    parameter logic [31:0] C_XFER_LEN                 = 32'h0000_0400,
    parameter int          C_POLL_MAX                 = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    output logic                              TXN_DONE,
    output logic                              ERROR
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int CNT_W = $clog2(C_POLL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_POLL_MAX - 1);

    localparam logic [31:0] OFF_CR  = 32'h00;
    localparam logic [31:0] OFF_SR  = 32'h04;
    localparam logic [31:0] OFF_SA  = 32'h18;
    localparam logic [31:0] OFF_LEN = 32'h28;

    typedef enum logic [2:0] {
        IDLE,
        WR_CR,
        WR_SA,
        WR_LEN,
        POLL,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       init_q;
    logic             start;
    logic             issued;
    logic [CNT_W-1:0] poll_cnt;

    logic [31:0]      wr_off;
    logic [31:0]      wr_val;
    state_t           wr_next;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // init_q[0] is the newest sample, init_q[1] the one before it.
    assign start = init_q[0] & ~init_q[1];

    // Register address/data and successor for the current write state.
    always_comb begin
        wr_off  = OFF_CR;
        wr_val  = 32'h0000_0001;
        wr_next = WR_SA;
        unique case (state)
            WR_SA: begin
                wr_off  = OFF_SA;
                wr_val  = C_SRC_ADDR;
                wr_next = WR_LEN;
            end
            WR_LEN: begin
                wr_off  = OFF_LEN;
                wr_val  = C_XFER_LEN;
                wr_next = POLL;
            end
            default: begin
                wr_off  = OFF_CR;
                wr_val  = 32'h0000_0001;
                wr_next = WR_SA;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            init_q        <= 2'b00;
            issued        <= 1'b0;
            poll_cnt      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            TXN_DONE      <= 1'b0;
            ERROR         <= 1'b0;
        end else begin
            init_q <= {init_q[0], INIT_AXI_TXN};
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WR_CR;
                        issued   <= 1'b0;
                        poll_cnt <= '0;
                        TXN_DONE <= 1'b0;
                        ERROR    <= 1'b0;
                    end
                end
                WR_CR, WR_SA, WR_LEN: begin
                    if (!issued) begin
                        M_AXI_AWADDR  <= AW'(C_M_TARGET_SLAVE_BASE_ADDR + wr_off);
                        M_AXI_WDATA   <= DW'(wr_val);
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        issued        <= 1'b1;
                    end else begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                            M_AXI_AWVALID <= 1'b0;
                        end
                        if (M_AXI_WVALID && M_AXI_WREADY) begin
                            M_AXI_WVALID <= 1'b0;
                        end
                        // BREADY is a single-cycle pulse raised after BVALID.
                        if (M_AXI_BREADY) begin
                            M_AXI_BREADY <= 1'b0;
                            if (M_AXI_BVALID) begin
                                issued <= 1'b0;
                                state  <= wr_next;
                                if (M_AXI_BRESP != 2'b00) begin
                                    ERROR <= 1'b1;
                                end
                            end
                        end else if (M_AXI_BVALID) begin
                            M_AXI_BREADY <= 1'b1;
                        end
                    end
                end
                POLL: begin
                    if (!issued) begin
                        M_AXI_ARADDR  <= AW'(C_M_TARGET_SLAVE_BASE_ADDR + OFF_SR);
                        M_AXI_ARVALID <= 1'b1;
                        issued        <= 1'b1;
                    end else begin
                        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                            M_AXI_ARVALID <= 1'b0;
                        end
                        if (M_AXI_RREADY) begin
                            M_AXI_RREADY <= 1'b0;
                            if (M_AXI_RVALID) begin
                                issued   <= 1'b0;
                                poll_cnt <= poll_cnt + CNT_W'(1);
                                if (M_AXI_RRESP != 2'b00) begin
                                    ERROR <= 1'b1;
                                end
                                // DMASR error bits win over Idle/IOC.
                                if (|M_AXI_RDATA[6:4]) begin
                                    ERROR    <= 1'b1;
                                    TXN_DONE <= 1'b1;
                                    state    <= DONE;
                                end else if (M_AXI_RDATA[1] || M_AXI_RDATA[12]) begin
                                    TXN_DONE <= 1'b1;
                                    state    <= DONE;
                                end else if (poll_cnt == CNT_LAST) begin
                                    ERROR    <= 1'b1;
                                    TXN_DONE <= 1'b1;
                                    state    <= DONE;
                                end
                            end
                        end else if (M_AXI_RVALID) begin
                            M_AXI_RREADY <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_mm2s_lite_ctrl.sv
// Self-checking bench for axi_dma_mm2s_lite_ctrl: a behavioural AXI4-Lite
// slave with programmable delays/responses, directed vectors and sequences.
module tb_axi_dma_mm2s_lite_ctrl;

    localparam logic [31:0] BASE = 32'h4040_0000;
    localparam logic [31:0] SRC  = 32'h8765_4320;
    localparam logic [31:0] LEN  = 32'h0000_0400;
    localparam int          PMAX = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic        txn_done, error;

    always #5 clk = ~clk;

    axi_dma_mm2s_lite_ctrl #(
        .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_SRC_ADDR(SRC),
        .C_XFER_LEN(LEN),
        .C_POLL_MAX(PMAX)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .INIT_AXI_TXN(init),
        .M_AXI_AWADDR(awaddr),
        .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready),
        .TXN_DONE(txn_done),
        .ERROR(error)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Slave configuration.
    int          aw_dly, w_dly, ar_dly, n_zero;
    logic [1:0]  bresp_sa, rresp_last;
    logic [31:0] final_sr;

    // Slave observations.
    logic [31:0] wa [8];
    logic [31:0] wd [8];
    int wr_n, rd_n, rd_bad, viol, aw_cyc0, w_cyc0, aw_seen;

    // Slave internal state.
    int          aw_cnt, w_cnt, ar_cnt, awc, wc;
    logic        aw_got, w_got, ar_got, b_pend, r_pend;
    logic [31:0] cap_a, cap_d;

    task automatic slave_clear();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; awc = 0; wc = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        cap_a = 0; cap_d = 0;
    endtask

    // Behavioural slave, evaluated on the falling edge.
    initial begin
        slave_clear();
        aw_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_clear();
                continue;
            end
            // AW
            if (awvalid) begin
                aw_seen++;
                awc++;
                if (aw_got) viol++;
            end
            if (awready) begin
                awready = 0;
                aw_got = 1;
            end else if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    awready = 1;
                    cap_a = awaddr;
                end else aw_cnt++;
            end
            // W
            if (wvalid) begin
                wc++;
                if (w_got) viol++;
            end
            if (wready) begin
                wready = 0;
                w_got = 1;
            end else if (wvalid && !w_got) begin
                if (w_cnt >= w_dly) begin
                    wready = 1;
                    cap_d = wdata;
                end else w_cnt++;
            end
            // B
            if (bready && !bvalid) viol++;
            if (b_pend) begin
                bvalid = 0;
                b_pend = 0;
                if (wr_n < 8) begin
                    wa[wr_n] = cap_a;
                    wd[wr_n] = cap_d;
                end
                if (wr_n == 0) begin
                    aw_cyc0 = awc;
                    w_cyc0 = wc;
                end
                wr_n++;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                awc = 0; wc = 0;
            end else if (bvalid && bready) begin
                b_pend = 1;
            end else if (aw_got && w_got && !bvalid) begin
                bvalid = 1;
                bresp = (wr_n == 1) ? bresp_sa : 2'b00;
            end
            // AR
            if (arvalid && ar_got) viol++;
            if (arready) begin
                arready = 0;
                ar_got = 1;
            end else if (arvalid && !ar_got) begin
                if (ar_cnt >= ar_dly) begin
                    arready = 1;
                    if (araddr !== BASE + 32'h4) rd_bad++;
                end else ar_cnt++;
            end
            // R
            if (rready && !rvalid) viol++;
            if (r_pend) begin
                rvalid = 0;
                r_pend = 0;
                rd_n++;
                ar_got = 0;
                ar_cnt = 0;
            end else if (rvalid && rready) begin
                r_pend = 1;
            end else if (ar_got && !rvalid) begin
                rvalid = 1;
                if (rd_n < n_zero) begin
                    rdata = 0;
                    rresp = 0;
                end else begin
                    rdata = final_sr;
                    rresp = rresp_last;
                end
            end
        end
    end

    typedef struct {
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        logic [1:0]  bresp_sa;
        logic [1:0]  rresp;
        int          n_zero;
        logic [31:0] sr;
        int          exp_reads;
        logic        exp_err;
    } vec_t;

    vec_t v [9];

    task automatic run_vec(input vec_t t, input int idx);
        int cyc;
        aw_dly = t.aw_dly; w_dly = t.w_dly; ar_dly = t.ar_dly;
        bresp_sa = t.bresp_sa; rresp_last = t.rresp;
        n_zero = t.n_zero; final_sr = t.sr;
        wr_n = 0; rd_n = 0; rd_bad = 0; viol = 0;
        aw_cyc0 = -1; w_cyc0 = -1;
        @(negedge clk);
        init = 1;
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_start_clears", idx), {30'd0, txn_done, error}, 0);
        cyc = 0;
        while (!txn_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_done", idx), txn_done, 1);
        chk($sformatf("v%0d_error", idx), error, t.exp_err);
        // INIT still high: no new edge, so no restart.
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_hold", idx), txn_done, 1);
        chk($sformatf("v%0d_writes", idx), wr_n, 3);
        chk($sformatf("v%0d_cr_addr", idx), wa[0], BASE);
        chk($sformatf("v%0d_cr_data", idx), wd[0], 32'h1);
        chk($sformatf("v%0d_sa_addr", idx), wa[1], BASE + 32'h18);
        chk($sformatf("v%0d_sa_data", idx), wd[1], SRC);
        chk($sformatf("v%0d_len_addr", idx), wa[2], BASE + 32'h28);
        chk($sformatf("v%0d_len_data", idx), wd[2], LEN);
        chk($sformatf("v%0d_reads", idx), rd_n, t.exp_reads);
        chk($sformatf("v%0d_rd_addr_bad", idx), rd_bad, 0);
        chk($sformatf("v%0d_protocol", idx), viol, 0);
        chk($sformatf("v%0d_aw_cycles", idx), aw_cyc0, t.aw_dly + 1);
        chk($sformatf("v%0d_w_cycles", idx), w_cyc0, t.w_dly + 1);
        init = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen0;
        v[0] = '{0, 0, 0, 2'b00, 2'b00, 0,   32'h0000_0002, 1, 1'b0};
        v[1] = '{3, 0, 0, 2'b00, 2'b00, 0,   32'h0000_0002, 1, 1'b0};
        v[2] = '{0, 2, 2, 2'b00, 2'b00, 0,   32'h0000_0002, 1, 1'b0};
        v[3] = '{0, 0, 0, 2'b00, 2'b00, 5,   32'h0000_1000, 6, 1'b0};
        v[4] = '{0, 0, 0, 2'b10, 2'b00, 0,   32'h0000_0002, 1, 1'b1};
        v[5] = '{1, 1, 1, 2'b00, 2'b00, 100, 32'h0000_0000, PMAX, 1'b1};
        v[6] = '{0, 0, 0, 2'b00, 2'b00, 0,   32'h0000_0020, 1, 1'b1};
        v[7] = '{0, 0, 0, 2'b00, 2'b00, 2,   32'h0000_0012, 3, 1'b1};
        v[8] = '{0, 0, 0, 2'b00, 2'b10, 0,   32'h0000_0002, 1, 1'b1};
        aw_dly = 0; w_dly = 0; ar_dly = 0; n_zero = 0;
        bresp_sa = 0; rresp_last = 0; final_sr = 32'h2;
        wr_n = 0; rd_n = 0; rd_bad = 0; viol = 0;
        aw_cyc0 = 0; w_cyc0 = 0;

        // Reset state.
        #100;
        chk("reset_ctrl",
            {25'd0, awvalid, wvalid, bready, arvalid, rready, txn_done, error}, 0);
        chk("reset_addr_data", awaddr | wdata | araddr, 0);
        @(negedge clk);
        rst_n = 1;

        // INIT stays low: no edge, no write.
        for (int i = 0; i < 10; i++) begin
            init = 0;
            @(negedge clk);
        end
        chk("no_edge_no_aw", aw_seen, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(v[i], i);
        end

        // Reset while polling.
        n_zero = 1000; final_sr = 0; rresp_last = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_sa = 0;
        wr_n = 0; rd_n = 0;
        init = 1;
        cyc = 0;
        while (rd_n < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("poll_reached", rd_n >= 2, 1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_ctrl",
            {25'd0, awvalid, wvalid, bready, arvalid, rready, txn_done, error}, 0);
        chk("async_reset_addr_data", awaddr | wdata | araddr, 0);
        init = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        seen0 = aw_seen;
        repeat (10) @(negedge clk);
        chk("idle_after_reset", aw_seen - seen0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
